// File: rtl/smaesh_stream_ctrl_pkg.sv
// Shared definitions for the SMAesh stream controller: FSM state encoding
// and the unmasked AES block width.
package smaesh_stream_ctrl_pkg;

  localparam int unsigned BLK_W = 128;

  typedef enum logic [1:0] {
    ST_UNSEEDED  = 2'd0,
    ST_RESEEDING = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

endpackage

// File: rtl/smaesh_share_fifo.sv
// DEPTH-entry FIFO of ciphertext shares. The head is read straight out of the
// storage registers, so a push becomes visible on out_valid one cycle later.
module smaesh_share_fifo
  import smaesh_stream_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * BLK_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign out_valid = (cnt_q != '0);
  assign out_data  = mem[rd_ptr];
  assign count     = cnt_q;
  assign full      = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/smaesh_stream_ctrl.sv
// Seeding FSM, credit-based admission and ciphertext buffering between the
// SVRS stream ports and the masked AES core / PRNG. Option: SMAESH_RESEED_LOCK_EN.
module smaesh_stream_ctrl
  import smaesh_stream_ctrl_pkg::*;
#(
  parameter int unsigned d               = 2,
  parameter int unsigned DEPTH           = 2,
  parameter int unsigned RESEED_INTERVAL = 0,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_seed_valid,
  output logic                  in_seed_ready,
  output logic                  core_valid_in,
  input  logic                  core_in_ready,
  input  logic                  core_busy,
  input  logic                  core_cipher_valid,
  output logic                  core_out_ready,
  input  logic [BLK_W*d-1:0]    core_ciphertext,
  output logic                  prng_start_reseed,
  input  logic                  prng_out_valid,
  input  logic                  prng_busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLK_W*d-1:0]    out_ciphertext,
  output logic                  reseed_due,
  output logic [CNT_W-1:0]      blk_count
);

  localparam int unsigned DW    = BLK_W * d;
  localparam int unsigned FC_W  = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = FC_W + 1;

  state_t           state;
  state_t           state_nxt;
  logic             busy_q;
  logic             busy_fall;
  logic             accept_ok;
  logic             lock;
  logic             in_fire;
  logic             core_out_fire;
  logic             fifo_full;
  logic [FC_W-1:0]  inflight;
  logic [FC_W-1:0]  fifo_count;
  logic [OCC_W-1:0] occupancy;

`ifdef SMAESH_RESEED_LOCK_EN
  assign lock = reseed_due;
`else
  assign lock = 1'b0;
`endif

  assign busy_fall     = busy_q & ~prng_busy;
  assign occupancy     = {1'b0, inflight} + {1'b0, fifo_count};
  assign in_fire       = core_valid_in & core_in_ready;
  assign core_out_fire = core_cipher_valid & core_out_ready;
  assign core_out_ready = ~fifo_full;

  assign reseed_due = (RESEED_INTERVAL != 0) &&
                      (64'(blk_count) >= 64'(RESEED_INTERVAL));

  always_comb begin
    state_nxt         = state;
    prng_start_reseed = 1'b0;
    accept_ok         = 1'b0;
    core_valid_in     = 1'b0;
    in_ready          = 1'b0;

    // Blocks counted in flight plus buffered never exceed DEPTH, so the core
    // always finds room for its result.
    prng_start_reseed = in_seed_valid & ~in_valid & ~core_busy &
                        (inflight == '0) & (state != ST_RESEEDING);
    accept_ok         = (state == ST_RUN) & prng_out_valid &
                        (occupancy < OCC_W'(DEPTH)) & ~lock;
    core_valid_in     = in_valid & accept_ok;
    in_ready          = core_in_ready & accept_ok;

    case (state)
      ST_UNSEEDED:  if (prng_start_reseed) state_nxt = ST_RESEEDING;
      ST_RESEEDING: if (busy_fall)         state_nxt = ST_RUN;
      ST_RUN:       if (prng_start_reseed) state_nxt = ST_RESEEDING;
      default:                             state_nxt = ST_UNSEEDED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_UNSEEDED;
      busy_q        <= 1'b0;
      in_seed_ready <= 1'b0;
      inflight      <= '0;
      blk_count     <= '0;
    end else begin
      state         <= state_nxt;
      busy_q        <= prng_busy;
      in_seed_ready <= prng_busy & ~busy_q;

      case ({in_fire, core_out_fire})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      if (in_seed_ready) begin
        blk_count <= '0;
      end else if (in_fire && (blk_count != '1)) begin
        blk_count <= blk_count + 1'b1;
      end
    end
  end

  smaesh_share_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (core_out_fire),
    .push_data (core_ciphertext),
    .pop       (out_valid & out_ready),
    .out_valid (out_valid),
    .out_data  (out_ciphertext),
    .count     (fifo_count),
    .full      (fifo_full)
  );

endmodule
